// File: rtl/latch_bank_reader_pkg.sv
// Shared definitions for the latch bank reader: FSM state encoding and default geometry.
package latch_bank_reader_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_e;

endpackage

// File: rtl/latch_bank_reader_if.sv
// Write port, read-out request and serial output handshake of the latch bank reader.
interface latch_bank_reader_if
    import latch_bank_reader_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             start;
    logic [AW-1:0]    rd_addr;
    logic             sout;
    logic             sout_valid;
    logic             sout_ready;
    logic             busy;
    logic             done;

    modport master (
        output wr_en, wr_addr, wr_data, start, rd_addr, sout_ready,
        input  sout, sout_valid, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, rd_addr, sout_ready,
        output sout, sout_valid, busy, done
    );

endinterface

// File: rtl/latch_bank_storage.sv
// DEPTH x WIDTH flip-flop bank with one synchronous write port and one combinational read port.
module latch_bank_storage
    import latch_bank_reader_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read sees the pre-edge contents, so a same-cycle write never leaks into a snapshot.
    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/latch_bank_reader.sv
// Snapshots one storage word on start and shifts it out MSB first over a valid/ready handshake.
module latch_bank_reader
    import latch_bank_reader_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    latch_bank_reader_if.slave bus
);

    localparam int unsigned   CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_sout_valid;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_rd_word;
    logic             w_xfer;

    latch_bank_storage #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_storage (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (bus.wr_en),
        .i_wr_addr (bus.wr_addr),
        .i_wr_data (bus.wr_data),
        .i_rd_addr (bus.rd_addr),
        .o_rd_data (w_rd_word)
    );

    assign w_xfer = r_sout_valid & bus.sout_ready;

    // The shift register is all-zero outside SHIFT, so its MSB doubles as a registered sout.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_sout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_shift      <= w_rd_word;
                        r_cnt        <= CNT_LAST;
                        r_sout_valid <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= StShift;
                    end
                end
                StShift: begin
                    if (w_xfer) begin
                        if (r_cnt == '0) begin
                            r_shift      <= '0;
                            r_sout_valid <= 1'b0;
                            r_done       <= 1'b1;
                            r_state      <= StDone;
                        end else begin
                            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                            r_cnt   <= r_cnt - CW'(1);
                        end
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_shift      <= '0;
                    r_cnt        <= '0;
                    r_sout_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b0;
                    r_state      <= StIdle;
                end
            endcase
        end
    end

    assign bus.sout       = r_shift[WIDTH-1];
    assign bus.sout_valid = r_sout_valid;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule

// File: tb/tb_latch_bank_reader.sv
// Scoreboard bench: the driver queues expected bits per read-out, a monitor checks each transfer.
module tb_latch_bank_reader;
    import latch_bank_reader_pkg::*;

    localparam int unsigned W  = DEF_WIDTH;
    localparam int unsigned D  = DEF_DEPTH;
    localparam int unsigned AW = $clog2(D);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    latch_bank_reader_if #(.WIDTH(W), .DEPTH(D)) bus ();

    latch_bank_reader #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_pending = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int ready_mode = 0;
    bit bg_wr = 1'b0;
    bit exp_bits[$];
    logic [W-1:0] mem [D];
    logic prev_hold = 1'b0;
    logic prev_sout = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // 0: ready always high, 1: toggling, 2: random
    always @(negedge clk) begin
        case (ready_mode)
            0:       bus.sout_ready = 1'b1;
            1:       bus.sout_ready = ~bus.sout_ready;
            default: bus.sout_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: samples late in the low phase, well away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (!bus.sout_valid) check("sout_zero_when_invalid", 32'(bus.sout), 0);
                if (prev_hold) check("hold_while_stalled", {bus.sout_valid, bus.sout},
                                     {1'b1, prev_sout});
                if (bus.sout_valid && bus.sout_ready) begin
                    if (exp_bits.size() == 0) check("unexpected_bit", 1, 0);
                    else check("serial_bit", 32'(bus.sout), 32'(exp_bits.pop_front()));
                end
                if (bus.done) begin
                    check("done_expected", 32'(done_pending > 0), 1);
                    check("done_state", {bus.busy, bus.sout_valid}, 2'b10);
                    if (done_pending > 0) done_pending--;
                    done_cyc = cyc;
                    done_cnt++;
                end
                prev_hold = bus.sout_valid && !bus.sout_ready;
                prev_sout = bus.sout;
            end
        end
    end

    task automatic push_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) exp_bits.push_back(w[i]);
        done_pending++;
    endtask

    task automatic do_write(input int a, input logic [W-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(a);
        bus.wr_data = d;
        mem[a]      = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic do_read(input int a, input int mode, input bit same_wr,
                           input logic [W-1:0] wd, input int intf_addr);
        int c;
        int base;
        int t;
        int wa;
        ready_mode = mode;
        tick();
        base = done_cnt;
        bus.start   = 1'b1;
        bus.rd_addr = AW'(a);
        push_word(mem[a]);
        if (same_wr) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = AW'(a);
            bus.wr_data = wd;
            mem[a]      = wd;
        end
        c = cyc;
        tick();
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        check("first_bit_valid", 32'(bus.sout_valid), 1);
        check("busy_in_readout", 32'(bus.busy), 1);
        t = 0;
        while (done_cnt == base && t < 300) begin
            bus.start = (intf_addr >= 0 && t == 2);
            if (intf_addr >= 0) bus.rd_addr = AW'(intf_addr);
            if (bg_wr && $urandom_range(0, 1) == 1) begin
                wa = int'($urandom_range(0, D - 1));
                bus.wr_en   = 1'b1;
                bus.wr_addr = AW'(wa);
                bus.wr_data = W'($urandom);
                mem[wa]     = bus.wr_data;
            end else begin
                bus.wr_en = 1'b0;
            end
            tick();
            t++;
            if (intf_addr >= 0 && t == 3) check("busy_ignores_start", 32'(bus.busy), 1);
        end
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        if (done_cnt == base) check("done_timeout", 0, 1);
        else if (mode == 0) check("done_latency", 32'(done_cyc - c), W + 1);
        check("bits_consumed", exp_bits.size(), 0);
    endtask

    task automatic do_reset_mid(input int a);
        int base;
        ready_mode = 0;
        tick();
        bus.start   = 1'b1;
        bus.rd_addr = AW'(a);
        push_word(mem[a]);
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        base = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_bits.delete();
        done_pending = 0;
        for (int i = 0; i < D; i++) mem[i] = '0;
        check("rst_abort_outputs", {bus.sout_valid, bus.busy, bus.done, bus.sout}, 4'b0000);
        repeat (W + 4) tick();
        check("no_done_after_abort", done_cnt, base);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start = 1'b0;
        bus.rd_addr = '0;
        bus.sout_ready = 1'b1;
        for (int i = 0; i < D; i++) mem[i] = '0;
        repeat (3) tick();
        check("reset_outputs", {bus.sout_valid, bus.busy, bus.done, bus.sout}, 4'b0000);
        rst = 1'b0;
        tick();
        check("idle_outputs", {bus.sout_valid, bus.busy, bus.done, bus.sout}, 4'b0000);

        do_write(2, 8'hA5);
        do_read(2, 0, 1'b0, '0, -1);
        do_write(1, 8'h3C);
        do_read(1, 1, 1'b0, '0, -1);
        do_write(0, 8'hFF);
        do_read(0, 0, 1'b1, 8'h00, -1);
        do_read(0, 0, 1'b0, '0, -1);
        do_write(3, 8'h81);
        do_read(3, 0, 1'b0, '0, 2);

        bg_wr = 1'b1;
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(int'($urandom_range(0, D - 1)), W'($urandom));
            do_read(int'($urandom_range(0, D - 1)), int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), W'($urandom), -1);
        end
        bg_wr = 1'b0;

        do_write(2, 8'h5A);
        do_write(1, 8'hC3);
        do_reset_mid(2);
        for (int a = 0; a < D; a++) do_read(a, 0, 1'b0, '0, -1);

        repeat (4) tick();
        check("final_done_pending", done_pending, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
